control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit for the Mini-SRC datapath: replaces hand-sequenced testbench stimulus by stepping the fetch/execute states T0–T5 and driving the datapath's control strobes directly. Generalises the single fixed `andi` sequence to every register-register and immediate ALU instruction, plus `nop` and `halt`. It has run/idle control, an illegal-opcode flag, and an optional memory-wait stall. Sits beside `Datapath`; its strobes connect one-to-one to the Datapath ports of the same name.

## Interface
- `OPCODE_W`, 5: opcode width; opcode is IR[31:32-OPCODE_W].
- `STEP_W`, 3: width of the `step` status output.
- `clock`  in  1: sole clock; all state changes on rising edge.
- `clear`  in  1: synchronous, active-high reset.
- `run_in`  in  1: level; enables instruction sequencing.
- `opcode`  in  OPCODE_W: IR opcode field, valid from T3 onward.
- `mem_ready`  in  1: memory read complete; used only with `CTRL_MEM_WAIT_EN`.
- `PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin`  out  1 each: fetch strobes.
- `Gra, Grb, Grc, Rout, Rin, Yin, Cout, Zlowin, Zlowout`  out  1 each: execute strobes.
- `alu_op`  out  OPCODE_W: ALU operation select.
- `step`  out  STEP_W: current T-step, 0–5; 7 in IDLE/HALTED.
- `halted`  out  1: high in HALTED.
- `illegal`  out  1: one-cycle pulse on an undecodable opcode.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, HALTED.
- Moore outputs: each strobe is high for the entire cycle of its state and low otherwise. No mid-cycle pulsing.
- IDLE: all strobes low. Go to T0 when `run_in`=1.
- T0: PCout, MARin, IncPC, PCin. Go to T1.
- T1: Read, MDRin. Go to T2.
- T2: MDRout, IRin. Go to T3.
- T3: Grb, Rout, Yin for ALU classes; decode `opcode`:
  - R-type (add, sub, and, or): go to T4.
  - I-type (addi, andi, ori): go to T4.
  - nop: no strobes; go to T0, or to IDLE if `run_in`=0.
  - halt: no strobes; go to HALTED.
  - any other opcode: no strobes; `illegal`=1; go to T0, or to IDLE if `run_in`=0.
- T4:
  - R-type: Grc, Rout, Zlowin; `alu_op`=opcode.
  - I-type: Cout, Zlowin; `alu_op`=opcode.
  - Go to T5.
- T5: Zlowout, Gra, Rin. Go to T0 if `run_in`=1, else IDLE.
- `run_in` is sampled only in IDLE and at instruction boundaries (T3 for nop/illegal, T5). Dropping it mid-instruction completes the current instruction.
- HALTED: all strobes low; `halted`=1. Only `clear` exits, to IDLE.
- `alu_op` is 0 outside T4.

## Timing
- `clear` is sampled at the rising edge and overrides everything, including mid-instruction and HALTED. Next state is IDLE; every output is 0 except `step`=7.
- Latency from `run_in` rising in IDLE to T0: 1 cycle.
- Instruction length:
  - ALU instruction: 6 cycles (T0–T5).
  - nop or illegal: 4 cycles (T0–T3).
- Back-to-back instructions: T5→T0 with no gap cycle.
- `opcode` must be stable during T3 and T4. The IR loads at the T2→T3 edge.

## Configuration
- `CTRL_MEM_WAIT_EN` defined:
  - T1 holds while `mem_ready`=0. Read and MDRin stay high throughout the hold.
  - T1 advances to T2 on the first edge with `mem_ready`=1.
  - `clear` still aborts a stalled T1.
- `CTRL_MEM_WAIT_EN` undefined: `mem_ready` is ignored and T1 always lasts 1 cycle.

## Structure
- Shared package `ctrl_pkg`:
  - state enum.
  - Opcode constants: add=00011, sub=00100, and=01010, or=01011, addi=01100, andi=01101, ori=01110, nop=11010, halt=11011.
  - Class enum: RTYPE, ITYPE, NOP, HALT, ILLEGAL.
- One sub-module `opcode_class_decode`: combinational mapping from opcode to class. It is reused later by the branch/memory extension.

## Test plan
- `clear`=1 for 2 cycles, then `run_in`=0 → sequencer stays in IDLE; all strobes 0; `step`=7.
- `run_in`=1, opcode=andi (01101) → one cycle each of T0..T5. T4 asserts Cout and Zlowin with `alu_op`=01101; T5 asserts Gra, Rin and Zlowout; then back to T0.
- opcode=add (00011) → T4 asserts Grc, Rout and Zlowin with `alu_op`=00011; Cout stays 0.
- opcode=11111 → `illegal` high for the single T3 cycle; next state T0; no Rin during the instruction.
- opcode=halt → `halted`=1 from the cycle after T3. Holds for 20 cycles with `run_in`=1. `clear` → IDLE.
- With `CTRL_MEM_WAIT_EN`, `mem_ready` low for 3 cycles → T1 lasts 4 cycles with Read high throughout. Separately, `clear` asserted during T4 → IDLE on the next cycle with all outputs 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the Mini-SRC hardwired control unit.
//   state_e    : sequencer states (IDLE, T0..T5, HALTED)
//   op_class_e : instruction classes produced by opcode_class_decode
//   Op*        : opcode encodings (IR[31:27])
package ctrl_pkg;

  localparam int unsigned OpcW = 5;

  typedef enum logic [2:0] {
    StIdle,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StHalted
  } state_e;

  typedef enum logic [2:0] {
    ClsRtype,
    ClsItype,
    ClsNop,
    ClsHalt,
    ClsIllegal
  } op_class_e;

  localparam logic [OpcW-1:0] OpAdd  = 5'b00011;
  localparam logic [OpcW-1:0] OpSub  = 5'b00100;
  localparam logic [OpcW-1:0] OpAnd  = 5'b01010;
  localparam logic [OpcW-1:0] OpOr   = 5'b01011;
  localparam logic [OpcW-1:0] OpAddi = 5'b01100;
  localparam logic [OpcW-1:0] OpAndi = 5'b01101;
  localparam logic [OpcW-1:0] OpOri  = 5'b01110;
  localparam logic [OpcW-1:0] OpNop  = 5'b11010;
  localparam logic [OpcW-1:0] OpHalt = 5'b11011;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode-to-class mapping for the control sequencer.
// Ports:
//   opcode   in  OPCODE_W : IR opcode field
//   op_class out          : RTYPE / ITYPE / NOP / HALT / ILLEGAL
module opcode_class_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_e           op_class
);

  always_comb begin
    op_class = ClsIllegal;
    case (opcode)
      OPCODE_W'(OpAdd), OPCODE_W'(OpSub),
      OPCODE_W'(OpAnd), OPCODE_W'(OpOr):   op_class = ClsRtype;
      OPCODE_W'(OpAddi), OPCODE_W'(OpAndi),
      OPCODE_W'(OpOri):                    op_class = ClsItype;
      OPCODE_W'(OpNop):                    op_class = ClsNop;
      OPCODE_W'(OpHalt):                   op_class = ClsHalt;
      default:                             op_class = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the Mini-SRC datapath. Steps T0..T5 and drives the
// datapath control strobes as Moore outputs (each strobe high for its whole state).
// Optional build macro: CTRL_MEM_WAIT_EN -- T1 holds until mem_ready is high.
// Ports:
//   clock, clear (sync, active-high)   run_in : enable sequencing (level)
//   opcode    : IR opcode, valid from T3  mem_ready : memory read done (wait build only)
//   PCout..IRin : fetch strobes           Gra..Zlowout : execute strobes
//   alu_op    : ALU select (T4 only)      step : T-step, 7 in IDLE/HALTED
//   halted    : high in HALTED            illegal : pulse in T3 on bad opcode
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 5,
  parameter int unsigned STEP_W   = 3
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run_in,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                Rout,
  output logic                Rin,
  output logic                Yin,
  output logic                Cout,
  output logic                Zlowin,
  output logic                Zlowout,
  output logic [OPCODE_W-1:0] alu_op,
  output logic [STEP_W-1:0]   step,
  output logic                halted,
  output logic                illegal
);

  state_e    state_q, state_d;
  op_class_e op_class;

  opcode_class_decode #(
    .OPCODE_W(OPCODE_W)
  ) u_decode (
    .opcode  (opcode),
    .op_class(op_class)
  );

`ifndef CTRL_MEM_WAIT_EN
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
`endif

  always_ff @(posedge clock) begin
    if (clear) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    PCout   = 1'b0;
    MARin   = 1'b0;
    IncPC   = 1'b0;
    PCin    = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rout    = 1'b0;
    Rin     = 1'b0;
    Yin     = 1'b0;
    Cout    = 1'b0;
    Zlowin  = 1'b0;
    Zlowout = 1'b0;
    alu_op  = '0;
    step    = STEP_W'(7);
    halted  = 1'b0;
    illegal = 1'b0;

    case (state_q)
      StIdle: begin
        if (run_in) state_d = StT0;
      end
      StT0: begin
        step    = STEP_W'(0);
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        PCin    = 1'b1;
        state_d = StT1;
      end
      StT1: begin
        step  = STEP_W'(1);
        Read  = 1'b1;
        MDRin = 1'b1;
`ifdef CTRL_MEM_WAIT_EN
        state_d = mem_ready ? StT2 : StT1;
`else
        state_d = StT2;
`endif
      end
      StT2: begin
        step    = STEP_W'(2);
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = StT3;
      end
      StT3: begin
        step = STEP_W'(3);
        case (op_class)
          ClsRtype, ClsItype: begin
            Grb     = 1'b1;
            Rout    = 1'b1;
            Yin     = 1'b1;
            state_d = StT4;
          end
          ClsNop:  state_d = run_in ? StT0 : StIdle;
          ClsHalt: state_d = StHalted;
          default: begin
            illegal = 1'b1;
            state_d = run_in ? StT0 : StIdle;
          end
        endcase
      end
      StT4: begin
        step   = STEP_W'(4);
        alu_op = opcode;
        case (op_class)
          ClsRtype: begin
            Grc    = 1'b1;
            Rout   = 1'b1;
            Zlowin = 1'b1;
          end
          ClsItype: begin
            Cout   = 1'b1;
            Zlowin = 1'b1;
          end
          default: ;
        endcase
        state_d = StT5;
      end
      StT5: begin
        step    = STEP_W'(5);
        Zlowout = 1'b1;
        Gra     = 1'b1;
        Rin     = 1'b1;
        state_d = run_in ? StT0 : StIdle;
      end
      StHalted: begin
        halted = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer. Inputs change and outputs
// are sampled on the falling clock edge; state changes on the rising edge.
module tb_control_sequencer;

  logic       clock;
  logic       clear;
  logic       run_in;
  logic [4:0] opcode;
  logic       mem_ready;
  logic       PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
  logic       Gra, Grb, Grc, Rout, Rin, Yin, Cout, Zlowin, Zlowout;
  logic [4:0] alu_op;
  logic [2:0] step;
  logic       halted;
  logic       illegal;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Strobe vector order: PCout MARin IncPC PCin Read MDRin MDRout IRin
  //                      Gra Grb Grc Rout Rin Yin Cout Zlowin Zlowout
  localparam logic [16:0] SNone = 17'h00000;
  localparam logic [16:0] ST0   = 17'h1E000;
  localparam logic [16:0] ST1   = 17'h01800;
  localparam logic [16:0] ST2   = 17'h00600;
  localparam logic [16:0] ST3   = 17'h000A8;
  localparam logic [16:0] ST4R  = 17'h00062;
  localparam logic [16:0] ST4I  = 17'h00006;
  localparam logic [16:0] ST5   = 17'h00111;

  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpAndi = 5'b01101;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;
  localparam logic [4:0] OpBad  = 5'b11111;

  logic [16:0] strobes;
  assign strobes = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
                    Gra, Grb, Grc, Rout, Rin, Yin, Cout, Zlowin, Zlowout};

  control_sequencer #(
    .OPCODE_W(5),
    .STEP_W  (3)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .run_in   (run_in),
    .opcode   (opcode),
    .mem_ready(mem_ready),
    .PCout    (PCout),
    .MARin    (MARin),
    .IncPC    (IncPC),
    .PCin     (PCin),
    .Read     (Read),
    .MDRin    (MDRin),
    .MDRout   (MDRout),
    .IRin     (IRin),
    .Gra      (Gra),
    .Grb      (Grb),
    .Grc      (Grc),
    .Rout     (Rout),
    .Rin      (Rin),
    .Yin      (Yin),
    .Cout     (Cout),
    .Zlowin   (Zlowin),
    .Zlowout  (Zlowout),
    .alu_op   (alu_op),
    .step     (step),
    .halted   (halted),
    .illegal  (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic expect_now(input string tag, input int unsigned exp_step,
                            input logic [16:0] exp_str, input logic [4:0] exp_alu,
                            input logic exp_ill, input logic exp_hlt);
    check({tag, ".step"},    32'(step),    32'(exp_step));
    check({tag, ".strobes"}, 32'(strobes), 32'(exp_str));
    check({tag, ".alu_op"},  32'(alu_op),  32'(exp_alu));
    check({tag, ".illegal"}, 32'(illegal), 32'(exp_ill));
    check({tag, ".halted"},  32'(halted),  32'(exp_hlt));
  endtask

  task automatic expect_cycle(input string tag, input int unsigned exp_step,
                              input logic [16:0] exp_str, input logic [4:0] exp_alu,
                              input logic exp_ill, input logic exp_hlt);
    @(posedge clock);
    @(negedge clock);
    expect_now(tag, exp_step, exp_str, exp_alu, exp_ill, exp_hlt);
  endtask

  task automatic fetch(input string tag);
    expect_cycle({tag, ".t0"}, 0, ST0, 5'd0, 1'b0, 1'b0);
    expect_cycle({tag, ".t1"}, 1, ST1, 5'd0, 1'b0, 1'b0);
    expect_cycle({tag, ".t2"}, 2, ST2, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    clear     = 1'b1;
    run_in    = 1'b0;
    opcode    = 5'd0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    expect_now("reset", 7, SNone, 5'd0, 1'b0, 1'b0);
    expect_cycle("idle", 7, SNone, 5'd0, 1'b0, 1'b0);

    // andi, then add back-to-back
    run_in = 1'b1;
    opcode = OpAndi;
    fetch("andi");
    expect_cycle("andi.t3", 3, ST3,  5'd0,   1'b0, 1'b0);
    expect_cycle("andi.t4", 4, ST4I, OpAndi, 1'b0, 1'b0);
    expect_cycle("andi.t5", 5, ST5,  5'd0,   1'b0, 1'b0);
    opcode = OpAdd;
    fetch("add");
    expect_cycle("add.t3", 3, ST3,  5'd0,  1'b0, 1'b0);
    expect_cycle("add.t4", 4, ST4R, OpAdd, 1'b0, 1'b0);
    expect_cycle("add.t5", 5, ST5,  5'd0,  1'b0, 1'b0);

    // illegal opcode: 4-cycle instruction, no register write
    opcode = OpBad;
    fetch("bad");
    expect_cycle("bad.t3", 3, SNone, 5'd0, 1'b1, 1'b0);
    opcode = OpNop;
    expect_cycle("nop.t0", 0, ST0, 5'd0, 1'b0, 1'b0);
    expect_cycle("nop.t1", 1, ST1, 5'd0, 1'b0, 1'b0);
    expect_cycle("nop.t2", 2, ST2, 5'd0, 1'b0, 1'b0);
    expect_cycle("nop.t3", 3, SNone, 5'd0, 1'b0, 1'b0);
    run_in = 1'b0;
    expect_cycle("nop.idle", 7, SNone, 5'd0, 1'b0, 1'b0);
    expect_cycle("idle2", 7, SNone, 5'd0, 1'b0, 1'b0);

    // run_in dropped mid-instruction: the instruction still completes
    run_in = 1'b1;
    opcode = OpAndi;
    expect_cycle("drop.t0", 0, ST0, 5'd0, 1'b0, 1'b0);
    run_in = 1'b0;
    expect_cycle("drop.t1", 1, ST1,  5'd0,   1'b0, 1'b0);
    expect_cycle("drop.t2", 2, ST2,  5'd0,   1'b0, 1'b0);
    expect_cycle("drop.t3", 3, ST3,  5'd0,   1'b0, 1'b0);
    expect_cycle("drop.t4", 4, ST4I, OpAndi, 1'b0, 1'b0);
    expect_cycle("drop.t5", 5, ST5,  5'd0,   1'b0, 1'b0);
    expect_cycle("drop.idle", 7, SNone, 5'd0, 1'b0, 1'b0);

    // halt: sticky with run_in high, only clear exits
    run_in = 1'b1;
    opcode = OpHalt;
    fetch("halt");
    expect_cycle("halt.t3", 3, SNone, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      expect_cycle("halted", 7, SNone, 5'd0, 1'b0, 1'b1);
    end
    clear = 1'b1;
    expect_cycle("halt.clear", 7, SNone, 5'd0, 1'b0, 1'b0);
    clear  = 1'b0;
    run_in = 1'b0;
    expect_cycle("halt.idle", 7, SNone, 5'd0, 1'b0, 1'b0);

    // clear during T4 aborts to IDLE
    run_in = 1'b1;
    opcode = OpAdd;
    fetch("abort");
    expect_cycle("abort.t3", 3, ST3,  5'd0,  1'b0, 1'b0);
    expect_cycle("abort.t4", 4, ST4R, OpAdd, 1'b0, 1'b0);
    clear = 1'b1;
    expect_cycle("abort.clear", 7, SNone, 5'd0, 1'b0, 1'b0);
    clear  = 1'b0;
    run_in = 1'b0;
    expect_cycle("abort.idle", 7, SNone, 5'd0, 1'b0, 1'b0);

`ifdef CTRL_MEM_WAIT_EN
    // mem_ready low for 3 sampling edges: T1 lasts 4 cycles
    run_in = 1'b1;
    opcode = OpAndi;
    expect_cycle("wait.t0", 0, ST0, 5'd0, 1'b0, 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_cycle("wait.t1", 1, ST1, 5'd0, 1'b0, 1'b0);
    end
    mem_ready = 1'b1;
    expect_cycle("wait.t2", 2, ST2,  5'd0,   1'b0, 1'b0);
    expect_cycle("wait.t3", 3, ST3,  5'd0,   1'b0, 1'b0);
    expect_cycle("wait.t4", 4, ST4I, OpAndi, 1'b0, 1'b0);
    run_in = 1'b0;
    expect_cycle("wait.t5", 5, ST5,  5'd0,   1'b0, 1'b0);
    expect_cycle("wait.idle", 7, SNone, 5'd0, 1'b0, 1'b0);

    // clear aborts a stalled T1
    run_in = 1'b1;
    expect_cycle("stall.t0", 0, ST0, 5'd0, 1'b0, 1'b0);
    mem_ready = 1'b0;
    expect_cycle("stall.t1a", 1, ST1, 5'd0, 1'b0, 1'b0);
    expect_cycle("stall.t1b", 1, ST1, 5'd0, 1'b0, 1'b0);
    clear = 1'b1;
    expect_cycle("stall.clear", 7, SNone, 5'd0, 1'b0, 1'b0);
    clear     = 1'b0;
    run_in    = 1'b0;
    mem_ready = 1'b1;
    expect_cycle("stall.idle", 7, SNone, 5'd0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
